// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: bus widths,
// the ROM chip-enable levels, the default reset vector and the FSM state
// encodings. The states are plain localparams so that older tools and
// legacy code can share the same constants.
package inst_fetch_ctrl_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [InstBus-1:0]     ZeroWord    = '0;
  localparam logic                   ChipEnable  = 1'b1;
  localparam logic                   ChipDisable = 1'b0;
  localparam logic [InstAddrBus-1:0] ResetVector = 32'h0000_0000;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FETCH  = 2'd1;
  localparam logic [1:0] STALL  = 2'd2;
  localparam logic [1:0] BRPEND = 2'd3;

  // Instructions are word aligned, so a redirect target keeps only its
  // word-address bits.
  function automatic logic [InstAddrBus-1:0] align_addr(input logic [InstAddrBus-1:0] addr);
    return {addr[InstAddrBus-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if_id.sv
// IF/ID pipeline register. Captures the fetched PC/instruction when
// load_i is set, inserts a bubble (valid low) when bubble_i is set and
// otherwise holds its contents, which is how a decode stall is honoured.
//   clk, rst_n      : clock, asynchronous active-low reset
//   load_i          : capture pc_i/inst_i as a valid instruction
//   bubble_i        : mark the register empty (takes priority over load_i)
//   pc_i, inst_i    : PC and instruction word being fetched
//   pc_o, inst_o    : registered PC and instruction for decode
//   valid_o         : pc_o/inst_o hold a real instruction
module inst_fetch_ctrl_if_id
  import inst_fetch_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_i,
  input  logic                   bubble_i,
  input  logic [InstAddrBus-1:0] pc_i,
  input  logic [InstBus-1:0]     inst_i,
  output logic [InstAddrBus-1:0] pc_o,
  output logic [InstBus-1:0]     inst_o,
  output logic                   valid_o
);

  logic [InstAddrBus-1:0] pc_q;
  logic [InstBus-1:0]     inst_q;
  logic                   valid_q;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      inst_q  <= ZeroWord;
      valid_q <= 1'b0;
    end else if (bubble_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      pc_q    <= pc_i;
      inst_q  <= inst_i;
      valid_q <= 1'b1;
    end
  end

  assign pc_o    = pc_q;
  assign inst_o  = inst_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller. Owns the PC and the fetch FSM, drives the
// instruction ROM, and hands fetched instructions to decode through the
// IF/ID register. A redirect seen while decode is stalled is parked in
// pend_addr and applied once the stall clears; the first one wins.
//   clk, rst             : clock, asynchronous active-low reset
//   stall                : decode cannot accept an instruction this cycle
//   branch_flag          : redirect requested this cycle
//   branch_target_addr   : redirect address (low two bits dropped)
//   rom_ce, rom_addr     : ROM chip enable and byte address (= PC)
//   rom_inst             : ROM read data, valid in the same cycle
//   if_pc/if_inst/if_valid : instruction handed to decode
//   misalign_err         : pulse when an accepted/latched target is unaligned
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] ResetVector = inst_fetch_ctrl_pkg::ResetVector
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target_addr,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        misalign_err
);

  logic [1:0]             state_q, state_d;
  logic [InstAddrBus-1:0] pc_q, pc_d;
  logic [InstAddrBus-1:0] pend_addr_q, pend_addr_d;
  logic                   load, bubble, misalign;
  logic [InstAddrBus-1:0] target;

  assign target = align_addr(branch_target_addr);

  // NOTE: every signal assigned here gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_addr_d = pend_addr_q;
    load        = 1'b0;
    bubble      = 1'b0;
    misalign    = 1'b0;
    unique case (state_q)
      IDLE: state_d = FETCH;
      // STALL with stall low behaves exactly like FETCH for that cycle.
      FETCH, STALL: begin
        if (!stall) begin
          state_d = FETCH;
          if (branch_flag) begin
            pc_d     = target;
            bubble   = 1'b1;
            misalign = |branch_target_addr[1:0];
          end else begin
            pc_d = pc_q + 32'd4;  // wraps modulo 2^32
            load = 1'b1;
          end
        end else if (branch_flag) begin
          state_d     = BRPEND;
          pend_addr_d = target;
          misalign    = |branch_target_addr[1:0];
        end else begin
          state_d = STALL;
        end
      end
      // Later redirects are ignored here; the parked one is applied as
      // soon as decode frees up.
      BRPEND: begin
        if (!stall) begin
          state_d = FETCH;
          pc_d    = pend_addr_q;
          bubble  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= ResetVector;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  assign rom_ce       = (state_q == IDLE) ? ChipDisable : ChipEnable;
  assign rom_addr     = pc_q;
  assign misalign_err = misalign;

  inst_fetch_ctrl_if_id u_if_id (
    .clk      (clk),
    .rst_n    (rst),
    .load_i   (load),
    .bubble_i (bubble),
    .pc_i     (pc_q),
    .inst_i   (rom_inst),
    .pc_o     (if_pc),
    .inst_o   (if_inst),
    .valid_o  (if_valid)
  );

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl. The ROM is modelled as word[i] = i. Each test
// task pushes the fetches it expects onto a scoreboard queue; a monitor
// pops and compares whenever a new valid instruction appears at if_*.
module tb_inst_fetch_ctrl;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target_addr = '0;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        misalign_err;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_t      exp_q[$];
  logic        last_valid = 1'b0;
  logic [31:0] last_pc = '0;

  always #5 clk = ~clk;

  assign rom_inst = rom_ce ? (rom_addr >> 2) : 32'h0;

  inst_fetch_ctrl #(.ResetVector(32'h0000_0000)) dut (
    .clk                (clk),
    .rst                (rst),
    .stall              (stall),
    .branch_flag        (branch_flag),
    .branch_target_addr (branch_target_addr),
    .rom_ce             (rom_ce),
    .rom_addr           (rom_addr),
    .rom_inst           (rom_inst),
    .if_pc              (if_pc),
    .if_inst            (if_inst),
    .if_valid           (if_valid),
    .misalign_err       (misalign_err)
  );

  // Scoreboard monitor: a new instruction is a valid if_* whose PC differs
  // from the previous sample or that follows a bubble.
  always @(negedge clk) begin
    fetch_t e;
    if (rst === 1'b1 && if_valid === 1'b1 && (!last_valid || if_pc !== last_pc)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_fetch: got pc=%h inst=%h, nothing expected", if_pc, if_inst);
      end else begin
        e = exp_q.pop_front();
        if (if_pc !== e.pc || if_inst !== e.inst) begin
          n_fail++;
          $display("FAIL fetch: got pc=%h inst=%h, expected pc=%h inst=%h", if_pc, if_inst, e.pc, e.inst);
        end
      end
    end
    last_valid = if_valid;
    last_pc    = if_pc;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic push(input logic [31:0] pc);
    fetch_t e;
    e.pc   = pc;
    e.inst = pc >> 2;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; stall = 1'b0; branch_flag = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (rom_ce !== 1'b0 || rom_addr !== 32'h0 || if_valid !== 1'b0 ||
        if_pc !== 32'h0 || if_inst !== 32'h0 || misalign_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: got ce=%b addr=%h valid=%b pc=%h inst=%h mis=%b, expected all zero",
               rom_ce, rom_addr, if_valid, if_pc, if_inst, misalign_err);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (rom_ce !== 1'b0) begin
      n_fail++;
      $display("FAIL ce_after_release: got %b, expected 0", rom_ce);
    end
    @(negedge clk);
    n_checks++;
    if (rom_ce !== 1'b1 || rom_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL ce_first_edge: got ce=%b addr=%h, expected ce=1 addr=0", rom_ce, rom_addr);
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) push(32'(i * 4));
    repeat (4) @(negedge clk);
    n_checks++;
    if (rom_addr !== 32'h10 || if_pc !== 32'hC || if_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL sequential_end: got addr=%h if_pc=%h valid=%b, expected addr=10 if_pc=c valid=1",
               rom_addr, if_pc, if_valid);
    end
  endtask

  task automatic test_stall();
    push(32'h0); push(32'h4);
    repeat (2) @(negedge clk);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (if_pc !== 32'h4 || if_inst !== 32'h1 || if_valid !== 1'b1 || rom_addr !== 32'h8) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got pc=%h inst=%h valid=%b addr=%h, expected 4/1/1/8",
                 i, if_pc, if_inst, if_valid, rom_addr);
      end
    end
    stall = 1'b0;
    push(32'h8);
    @(negedge clk);
    n_checks++;
    if (rom_addr !== 32'hC) begin
      n_fail++;
      $display("FAIL stall_resume: got addr=%h, expected c", rom_addr);
    end
  endtask

  task automatic test_branch();
    branch_flag = 1'b1; branch_target_addr = 32'h40;
    #1;
    n_checks++;
    if (misalign_err !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_aligned_err: got %b, expected 0", misalign_err);
    end
    push(32'h40);
    @(negedge clk);
    branch_flag = 1'b0;
    n_checks++;
    if (if_valid !== 1'b0 || rom_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL branch_bubble: got valid=%b addr=%h, expected valid=0 addr=40", if_valid, rom_addr);
    end
    @(negedge clk);
    n_checks++;
    if (if_valid !== 1'b1 || rom_addr !== 32'h44) begin
      n_fail++;
      $display("FAIL branch_after: got valid=%b addr=%h, expected valid=1 addr=44", if_valid, rom_addr);
    end
  endtask

  task automatic test_stall_branch();
    stall = 1'b1; branch_flag = 1'b1; branch_target_addr = 32'h80;
    @(negedge clk);
    n_checks++;
    if (if_pc !== 32'h40 || if_valid !== 1'b1 || rom_addr !== 32'h44) begin
      n_fail++;
      $display("FAIL brpend_hold: got pc=%h valid=%b addr=%h, expected 40/1/44", if_pc, if_valid, rom_addr);
    end
    branch_target_addr = 32'h102;
    #1;
    n_checks++;
    if (misalign_err !== 1'b0) begin
      n_fail++;
      $display("FAIL brpend_ignored_err: got %b, expected 0", misalign_err);
    end
    @(negedge clk);
    branch_flag = 1'b0; stall = 1'b0;
    push(32'h80);
    @(negedge clk);
    n_checks++;
    if (if_valid !== 1'b0 || rom_addr !== 32'h80) begin
      n_fail++;
      $display("FAIL brpend_bubble: got valid=%b addr=%h, expected valid=0 addr=80", if_valid, rom_addr);
    end
    @(negedge clk);
    n_checks++;
    if (rom_addr !== 32'h84) begin
      n_fail++;
      $display("FAIL brpend_after: got addr=%h, expected 84", rom_addr);
    end
  endtask

  task automatic test_misalign();
    branch_flag = 1'b1; branch_target_addr = 32'h43;
    #1;
    n_checks++;
    if (misalign_err !== 1'b1) begin
      n_fail++;
      $display("FAIL misalign_pulse: got %b, expected 1", misalign_err);
    end
    push(32'h40);
    @(negedge clk);
    branch_flag = 1'b0;
    #1;
    n_checks++;
    if (misalign_err !== 1'b0 || if_valid !== 1'b0 || rom_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL misalign_after: got mis=%b valid=%b addr=%h, expected 0/0/40", misalign_err, if_valid, rom_addr);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_brpend();
    stall = 1'b1; branch_flag = 1'b1; branch_target_addr = 32'h200;
    @(negedge clk);
    branch_flag = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (rom_ce !== 1'b0 || rom_addr !== 32'h0 || if_valid !== 1'b0 ||
        if_pc !== 32'h0 || if_inst !== 32'h0 || misalign_err !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got ce=%b addr=%h valid=%b pc=%h inst=%h mis=%b, expected all zero",
               rom_ce, rom_addr, if_valid, if_pc, if_inst, misalign_err);
    end
    @(negedge clk);
    stall = 1'b0; rst = 1'b1;
    push(32'h0); push(32'h4);
    repeat (3) @(negedge clk);
    n_checks++;
    if (rom_addr !== 32'h8) begin
      n_fail++;
      $display("FAIL reset_discard: got addr=%h, expected 8", rom_addr);
    end
  endtask

  task automatic test_wrap();
    fetch_t e;
    branch_flag = 1'b1; branch_target_addr = 32'hFFFF_FFF8;
    e.pc = 32'hFFFF_FFF8; e.inst = 32'h3FFF_FFFE; exp_q.push_back(e);
    e.pc = 32'hFFFF_FFFC; e.inst = 32'h3FFF_FFFF; exp_q.push_back(e);
    push(32'h0);
    @(negedge clk);
    branch_flag = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (rom_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL pc_wrap: got addr=%h, expected 0", rom_addr);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_reset();
    test_stall();
    test_branch();
    test_stall_branch();
    test_misalign();
    test_reset_brpend();
    test_wrap();
    stall = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 SHALL declare parameter ResetVector, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL declare port clk, input, 1, meaning the single system clock; all state changes on its rising edge.
REQ-003 SHALL declare port rst, input, 1, meaning reset: asynchronous and active-low (0 = reset asserted).
REQ-004 SHALL declare port stall, input, 1, meaning the decode stage cannot accept an instruction this cycle.
REQ-005 SHALL declare port branch_flag, input, 1, meaning a redirect is requested this cycle.
REQ-006 SHALL declare port branch_target_addr, input, 32, meaning the redirect address.
REQ-007 SHALL declare port rom_ce, output, 1, meaning instruction ROM chip enable (ChipEnable/ChipDisable).
REQ-008 SHALL declare port rom_addr, output, 32, meaning the byte address presented to the ROM (current PC).
REQ-009 SHALL declare port rom_inst, input, 32, meaning ROM read data, combinationally valid in the same cycle as rom_addr.
REQ-010 SHALL declare port if_pc, output, 32, meaning the PC of the instruction handed to decode.
REQ-011 SHALL declare port if_inst, output, 32, meaning the instruction handed to decode.
REQ-012 SHALL declare port if_valid, output, 1, meaning if_pc/if_inst hold a real instruction (0 = bubble).
REQ-013 SHALL declare port misalign_err, output, 1, meaning a one-cycle pulse on a redirect target with bits [1:0] != 0.

Function
REQ-014 SHALL implement the FSM states IDLE, FETCH, STALL and BRPEND.
REQ-015 IDLE: rom_ce low and pc = ResetVector; the FSM SHALL always go to FETCH on the first clock edge after reset release.
REQ-016 FETCH, stall=0, branch_flag=0: SHALL register if_pc<=pc, if_inst<=rom_inst and if_valid<=1, then set pc<=pc+4.
REQ-017 FETCH, stall=0, branch_flag=1: SHALL set pc<=target and if_valid<=0 (one bubble), and remain in FETCH.
REQ-018 FETCH, stall=1, branch_flag=0: SHALL hold pc and all if_* outputs, and go to STALL.
REQ-019 FETCH or STALL, stall=1, branch_flag=1: SHALL latch target into pend_addr, hold if_*, and go to BRPEND.
REQ-020 STALL SHALL hold while stall=1; when stall=0 it SHALL act as FETCH for that cycle, including a branch_flag seen in the same cycle.
REQ-021 BRPEND SHALL hold if_* while stall=1 and ignore further branch_flag (first redirect wins).
REQ-022 BRPEND with stall=0: SHALL set pc<=pend_addr and if_valid<=0, then go to FETCH.
REQ-023 rom_ce SHALL be high in every state except IDLE, and rom_addr SHALL always equal pc.
REQ-024 Redirect targets SHALL have bits [1:0] forced to 0, with misalign_err asserted for exactly the cycle the redirect is accepted or latched.
REQ-025 pc+4 SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 without error.
REQ-026 while rom_ce is low, the ROM returns ZeroWord and no instruction SHALL be registered.

Reset
REQ-027 on rst=0, independent of clk, SHALL force state=IDLE, pc=ResetVector, pend_addr=0, if_pc=0, if_inst=ZeroWord, if_valid=0, rom_ce=0 and misalign_err=0.
REQ-028 reset asserted mid-stall or with a branch pending SHALL discard the pending redirect; the first fetch after release SHALL be at ResetVector.

Structure
REQ-029 the shared defines package SHALL hold InstAddrBus, InstBus, ZeroWord, ChipEnable, ChipDisable, ResetVector and the FSM state encodings.
REQ-030 the IF/ID output register (if_pc, if_inst, if_valid, with hold and bubble controls) SHALL be implemented as sub-module if_id; PC and FSM stay in the top.

Verification
REQ-031 release reset, no stall, ROM word[i]=i -> rom_ce rises 1 cycle after release; if_inst sequence 0,1,2,3 with if_pc 0,4,8,C.
REQ-032 stall high for 3 cycles at pc=8 -> if_* frozen at pc 4/inst 1, rom_addr held at 8; fetch resumes with pc 8/inst 2.
REQ-033 branch_flag with target 0x40 at pc=C, stall=0 -> one if_valid=0 bubble, then if_pc=0x40.
REQ-034 stall=1 with branch to 0x80, then a second branch to 0x100 while still stalled, then stall=0 -> bubble, then if_pc=0x80; 0x100 is ignored.
REQ-035 branch target 0x43 -> misalign_err pulses for 1 cycle; next fetch at 0x40.
REQ-036 reset asserted mid-BRPEND, then released -> all outputs at reset values immediately; first if_pc=ResetVector; set pc near 0xFFFF_FFFC -> next fetch at 0.
